aibcr3_dcc_cal_ctrl: RTL and testbench
======================================

# aibcr3_dcc_cal_ctrl

Duty-cycle-correction calibration controller that sequences the 7-bit gray-coded DCC delay code consumed by the gray-to-thermometer decoder.
- Runs a bang-bang loop: settle after each code change, majority-vote a synchronised duty detector over a window, step a binary code by ±1, and drive its reflected-gray image.
- Declares lock after a programmable number of direction reversals.
- Sits between the DCC duty detector and the code decoder in the AIB clock path.

## Interface
- SETTLE_CYC, 15: cycles waited after each code update before sampling (≥1).
- AVG_LEN, 8: detector samples per vote; even, 2..64.
- LOCK_REV, 4: reversals/stalls needed to declare lock (1..15).
- INIT_CODE, 64: binary code loaded on reset (0..127).
- CLKIN  in  1  sole clock; all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- cal_en  in  1  level; high runs or holds calibration, low returns to idle.
- pd_up  in  1  duty detector; 1 = code must increase. Synchronous to CLKIN; its synchroniser is outside this block.
- grey  out  7  registered reflected gray of code, code ^ (code >> 1); feeds the decoder grey[6:0].
- code  out  7  registered binary code, for debug/readback.
- busy  out  1  high in SETTLE, SAMPLE and UPDATE.
- cal_done  out  1  high only in LOCKED.
- sat  out  1  sticky; set when a step is suppressed at 0 or 127.

## Operation
- Reset values: state IDLE, code = INIT_CODE, grey = gray(INIT_CODE), busy = 0, cal_done = 0, sat = 0. Internal counters, rev_cnt and the dir_valid flag are all 0.
- **IDLE:** when cal_en = 1, go to SETTLE.
  - Clear rev_cnt, dir_valid, sat and the counters.
  - Do not reload code; only RST restores INIT_CODE.
- **SETTLE:** count SETTLE_CYC cycles, then go to SAMPLE.
- **SAMPLE:** for AVG_LEN cycles, up_cnt += pd_up sampled in each cycle. Then go to UPDATE.
- **UPDATE** (1 cycle). With H = AVG_LEN/2:
  - If up_cnt > H, req = up. If up_cnt < H, req = down.
  - If up_cnt == H (tie): no step, rev_cnt += 1.
  - If req would move code beyond 0 or 127: no step, sat = 1, rev_cnt += 1.
  - Otherwise code ±= 1. If dir_valid and req ≠ last_dir, rev_cnt += 1. Then last_dir = req and dir_valid = 1.
  - If rev_cnt (after increment) == LOCK_REV, go to LOCKED. Else clear up_cnt and go to SETTLE.
- **LOCKED:** code is frozen and cal_done = 1. When cal_en = 0, go to IDLE.
- Deasserting cal_en in any non-IDLE state forces IDLE on the next edge.
  - This takes priority over every other transition.
  - code is held and any partial vote is discarded.
- rev_cnt is 4 bits and saturates. up_cnt is 7 bits.
- code and grey update on the same edge, so grey always changes by exactly one bit per step (glitch-free for the decoder).
- RST takes priority over cal_en and every state.

## Timing
- One iteration is SETTLE_CYC + AVG_LEN + 1 cycles; 24 with defaults.
- Timing of a code change:
  - The first code change is visible 1 + SETTLE_CYC + AVG_LEN + 1 edges after the edge sampling cal_en = 1: IDLE→SETTLE, then settle, then sample, then UPDATE.
  - Each later change follows the previous one by exactly one iteration.
- The first pd_up sample is taken on the edge that ends SETTLE_CYC cycles in SETTLE + 1. The last sample is taken on the edge entering UPDATE.
- cal_done rises on the same edge as the final code/grey update. busy falls on that edge.
- cal_en low → busy = 0 and cal_done = 0 one edge later.
- RST → all outputs at reset values one edge later.

## Test plan
- **Reset:** hold RST 2 cycles with cal_en = 1 → code = 64, grey = 7'h60, busy = 0, cal_done = 0, sat = 0.
- **Ramp:** pd_up = 1, cal_en = 1 from 64 →
  - code = 65 at cycle 25 after enable, then +1 every 24 cycles.
  - Exactly one grey bit toggles per step.
  - After reaching 127, four further UPDATEs set sat = 1, code stays 127, and cal_done = 1.
- **Dither:** votes alternate up, down, up, down, up from 64 → codes 65, 64, 65, 64, 65. rev_cnt reaches 4 on the fifth UPDATE, then LOCKED with code = 65 and cal_done = 1.
- **Tie:** every window has 4 ones in 8 → code stays 64 and cal_done = 1 after the fourth UPDATE (cycle 97).
- **Abort:** drop cal_en mid-SAMPLE with code = 70 →
  - IDLE next edge, busy = 0, code = 70.
  - Re-enable: first step from 70 occurs 25 cycles later, with rev_cnt restarted at 0.
- **Mid-run reset:** pulse RST for 1 cycle during SETTLE with code = 90 → next edge: code = 64, grey = 7'h60, state IDLE. With cal_en still high, SETTLE is entered one edge after RST falls.

Source files
------------

// File: rtl/aibcr3_dcc_cal_ctrl_if.sv
// aibcr3_dcc_cal_ctrl_if: detector input and gray-code/status outputs of the DCC calibration controller
interface aibcr3_dcc_cal_ctrl_if;
    logic       cal_en;
    logic       pd_up;
    logic [6:0] grey;
    logic [6:0] code;
    logic       busy;
    logic       cal_done;
    logic       sat;
    modport master (output cal_en, pd_up, input grey, code, busy, cal_done, sat);
    modport slave (input cal_en, pd_up, output grey, code, busy, cal_done, sat);
endinterface

// File: rtl/aibcr3_dcc_cal_ctrl.sv
// aibcr3_dcc_cal_ctrl: bang-bang DCC calibration loop driving a 7-bit gray delay code
module aibcr3_dcc_cal_ctrl #(
    parameter int SETTLE_CYC = 15,
    parameter int AVG_LEN    = 8,
    parameter int LOCK_REV   = 4,
    parameter int INIT_CODE  = 64
) (
    input logic                  CLKIN,
    input logic                  RST,
    aibcr3_dcc_cal_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, UPDATE, LOCKED} state_t;
    localparam logic [6:0]  INIT     = 7'(INIT_CODE);
    localparam logic [6:0]  HALF     = 7'(AVG_LEN / 2);
    localparam logic [15:0] SET_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] AVG_LAST = 16'(AVG_LEN - 1);
    localparam logic [3:0]  LOCK     = 4'(LOCK_REV);
    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [6:0]  up_cnt, up_n, code, code_n, grey;
    logic [3:0]  rev_cnt, rev_n, rev_inc_val;
    logic        dir_valid, dv_n, last_dir, ld_n, sat, sat_n;
    logic        step_up, step_dn, blocked, rev_inc;
    always_comb begin
        step_up     = up_cnt > HALF;
        step_dn     = up_cnt < HALF;
        blocked     = (step_up && code == 7'd127) || (step_dn && code == 7'd0);
        // tie, saturation stall, or genuine direction change all count toward lock
        rev_inc     = !(step_up || step_dn) || blocked || (dir_valid && last_dir != step_up);
        rev_inc_val = (rev_inc && rev_cnt != 4'hf) ? rev_cnt + 4'd1 : rev_cnt;
        state_n = state;
        cnt_n   = cnt;
        up_n    = up_cnt;
        rev_n   = rev_cnt;
        dv_n    = dir_valid;
        ld_n    = last_dir;
        code_n  = code;
        sat_n   = sat;
        case (state)
            IDLE: if (bus.cal_en) begin
                state_n = SETTLE;
                cnt_n   = '0;
                up_n    = '0;
                rev_n   = '0;
                dv_n    = 1'b0;
                sat_n   = 1'b0;
            end
            SETTLE: begin
                state_n = cnt == SET_LAST ? SAMPLE : SETTLE;
                cnt_n   = cnt == SET_LAST ? '0 : cnt + 16'd1;
            end
            SAMPLE: begin
                up_n    = up_cnt + 7'(bus.pd_up);
                state_n = cnt == AVG_LAST ? UPDATE : SAMPLE;
                cnt_n   = cnt == AVG_LAST ? '0 : cnt + 16'd1;
            end
            UPDATE: begin
                rev_n = rev_inc_val;
                if (blocked) sat_n = 1'b1;
                else if (step_up || step_dn) begin
                    code_n = step_up ? code + 7'd1 : code - 7'd1;
                    ld_n   = step_up;
                    dv_n   = 1'b1;
                end
                state_n = rev_inc_val == LOCK ? LOCKED : SETTLE;
                up_n    = '0;
                cnt_n   = '0;
            end
            default: ;
        endcase
        // dropping enable overrides everything: hold code, discard the partial vote
        if (!bus.cal_en && state != IDLE) begin
            state_n = IDLE;
            cnt_n   = '0;
            up_n    = '0;
            code_n  = code;
            sat_n   = sat;
            rev_n   = rev_cnt;
            dv_n    = dir_valid;
            ld_n    = last_dir;
        end
    end
    always_ff @(posedge CLKIN) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            up_cnt    <= '0;
            rev_cnt   <= '0;
            dir_valid <= 1'b0;
            last_dir  <= 1'b0;
            code      <= INIT;
            grey      <= INIT ^ (INIT >> 1);
            sat       <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            up_cnt    <= up_n;
            rev_cnt   <= rev_n;
            dir_valid <= dv_n;
            last_dir  <= ld_n;
            code      <= code_n;
            grey      <= code_n ^ (code_n >> 1);
            sat       <= sat_n;
        end
    end
    assign bus.code     = code;
    assign bus.grey     = grey;
    assign bus.sat      = sat;
    assign bus.busy     = state == SETTLE || state == SAMPLE || state == UPDATE;
    assign bus.cal_done = state == LOCKED;
endmodule

// File: tb/tb_aibcr3_dcc_cal_ctrl.sv
// tb_aibcr3_dcc_cal_ctrl: directed scoreboard bench for the DCC calibration controller
module tb_aibcr3_dcc_cal_ctrl;
    typedef struct {
        int         cyc;
        logic [6:0] code;
        logic       done;
        logic       nxt_pd;
    } ev_t;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  sb[$];
    aibcr3_dcc_cal_ctrl_if bus ();
    aibcr3_dcc_cal_ctrl dut (.CLKIN(clk), .RST(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask
    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic push(input int c, input int code, input logic done, input logic nxt);
        ev_t e;
        e.cyc = c;
        e.code = 7'(code);
        e.done = done;
        e.nxt_pd = nxt;
        sb.push_back(e);
    endtask
    // wait for each code change, compare it to the next queued expectation
    task automatic run_sb(input string tag);
        ev_t        e;
        logic [6:0] prev, prev_g, g;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            prev = bus.code;
            prev_g = bus.grey;
            while (bus.code === prev && cyc < e.cyc + 30) tick();
            g = e.code ^ (e.code >> 1);
            check({tag, "_code"}, 32'(bus.code), 32'(e.code));
            check({tag, "_cycle"}, 32'(cyc), 32'(e.cyc));
            check({tag, "_grey"}, 32'(bus.grey), 32'(g));
            check({tag, "_grey_onebit"}, 32'($countones(bus.grey ^ prev_g)), 32'd1);
            check({tag, "_done"}, 32'(bus.cal_done), 32'(e.done));
            bus.pd_up = e.nxt_pd;
        end
    endtask
    task automatic restart(input logic pd);
        bus.cal_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("restart_code", 32'(bus.code), 32'd64);
        bus.pd_up = pd;
        bus.cal_en = 1'b1;
        cyc = 0;
    endtask
    initial begin
        bit moved;
        rst = 1'b1;
        bus.cal_en = 1'b1;
        bus.pd_up = 1'b1;
        tick();
        tick();
        check("rst_code", 32'(bus.code), 32'd64);
        check("rst_grey", 32'(bus.grey), 32'h60);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.cal_done), 32'd0);
        check("rst_sat", 32'(bus.sat), 32'd0);
        rst = 1'b0;
        cyc = 0;
        tick();
        check("en_busy", 32'(bus.busy), 32'd1);
        for (int k = 1; k <= 26; k++) push(1 + 24 * k, 64 + k, 1'b0, 1'b1);
        run_sb("pre_reset");
        wait_to(630);
        rst = 1'b1;
        tick();
        check("midrst_code", 32'(bus.code), 32'd64);
        check("midrst_grey", 32'(bus.grey), 32'h60);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.cal_done), 32'd0);
        rst = 1'b0;
        tick();
        check("midrst_settle", 32'(bus.busy), 32'd1);
        cyc = 1;
        for (int k = 1; k <= 63; k++) push(1 + 24 * k, 64 + k, 1'b0, 1'b1);
        run_sb("ramp");
        wait_to(1536);
        check("ramp_sat_before", 32'(bus.sat), 32'd0);
        tick();
        check("ramp_sat", 32'(bus.sat), 32'd1);
        check("ramp_sat_code", 32'(bus.code), 32'd127);
        wait_to(1608);
        check("ramp_done_before", 32'(bus.cal_done), 32'd0);
        tick();
        check("ramp_done", 32'(bus.cal_done), 32'd1);
        check("ramp_busy_low", 32'(bus.busy), 32'd0);
        check("ramp_final_code", 32'(bus.code), 32'd127);
        bus.cal_en = 1'b0;
        tick();
        check("dis_busy", 32'(bus.busy), 32'd0);
        check("dis_done", 32'(bus.cal_done), 32'd0);
        check("dis_code", 32'(bus.code), 32'd127);
        restart(1'b1);
        push(25, 65, 1'b0, 1'b0);
        push(49, 64, 1'b0, 1'b1);
        push(73, 65, 1'b0, 1'b0);
        push(97, 64, 1'b0, 1'b1);
        push(121, 65, 1'b1, 1'b0);
        run_sb("dither");
        check("dither_busy", 32'(bus.busy), 32'd0);
        restart(1'b0);
        moved = 1'b0;
        while (cyc < 96) begin
            tick();
            bus.pd_up = ~bus.pd_up;
            if (bus.code !== 7'd64) moved = 1'b1;
        end
        check("tie_no_step", 32'(moved), 32'd0);
        check("tie_done_before", 32'(bus.cal_done), 32'd0);
        tick();
        check("tie_done", 32'(bus.cal_done), 32'd1);
        check("tie_code", 32'(bus.code), 32'd64);
        restart(1'b1);
        push(25, 65, 1'b0, 1'b0);
        push(49, 64, 1'b0, 1'b1);
        for (int k = 3; k <= 8; k++) push(1 + 24 * k, 62 + k, 1'b0, 1'b1);
        run_sb("pre_abort");
        wait_to(212);
        bus.cal_en = 1'b0;
        tick();
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.cal_done), 32'd0);
        check("abort_code", 32'(bus.code), 32'd70);
        tick();
        tick();
        check("abort_hold", 32'(bus.code), 32'd70);
        bus.pd_up = 1'b0;
        bus.cal_en = 1'b1;
        cyc = 0;
        push(25, 69, 1'b0, 1'b1);
        push(49, 70, 1'b0, 1'b0);
        push(73, 69, 1'b0, 1'b1);
        push(97, 70, 1'b0, 1'b0);
        push(121, 69, 1'b1, 1'b0);
        run_sb("reenable");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
